// File: rtl/multi_servo_driver_pkg.sv
// Shared definitions for the multi-channel servo driver.
// Holds the direction encoding and the button-pair decode used by every channel.
package multi_servo_driver_pkg;

    typedef enum logic [1:0] {
        DIR_STOP = 2'b00,
        DIR_CW   = 2'b01,
        DIR_CCW  = 2'b10
    } dir_e;

    // A single pressed button selects a direction; none or both means stop.
    function automatic dir_e decode_dir(input logic cw, input logic ccw);
        case ({cw, ccw})
            2'b10:   return DIR_CW;
            2'b01:   return DIR_CCW;
            default: return DIR_STOP;
        endcase
    endfunction

endpackage

// File: rtl/TickCounterRst.sv
// Free-running modulo-MAX counter with a terminal-count strobe.
// Ports:
//   CLK     system clock
//   rst     asynchronous, active-high reset (counter returns to 0)
//   tick_c  high during the cycle the counter holds MAX-1
module TickCounterRst #(
    parameter int unsigned MAX = 100
) (
    input  logic CLK,
    input  logic rst,
    output logic tick_c
);

    localparam int unsigned CNT_W = (MAX > 1) ? $clog2(MAX) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(MAX - 1);

    logic [CNT_W-1:0] cnt;

    assign tick_c = (cnt == LAST);

    // Wrap on the terminal count.
    always_ff @(posedge CLK or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (tick_c) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/servo_channel.sv
// One servo channel: button decode, per-frame pulse-width stepping with
// saturation, PWM compare and status flags.
// Ports:
//   CLK, RST        clock and asynchronous active-high reset
//   btn_cw/btn_ccw  direction request buttons
//   max_enable      use pw_max as an additional upper limit
//   pw_max          runtime upper limit in us
//   us_cnt          shared position within the frame, in us
//   frame_update    high in the single cycle where the width is reloaded
//   servo           registered PWM output
//   pw              current pulse width, us
//   direction       registered direction (dir_e encoding)
//   general_enable  pw at or above EN_THRESH, one cycle behind pw
//   at_limit        pw sits at the minimum or effective maximum, one cycle behind pw
module servo_channel
    import multi_servo_driver_pkg::*;
#(
    parameter int unsigned PW_W      = 16,
    parameter int unsigned PW_MIN    = 500,
    parameter int unsigned PW_MAX    = 2500,
    parameter int unsigned PW_INIT   = 1500,
    parameter int unsigned STEP_US   = 10,
    parameter int unsigned EN_THRESH = 100
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic            btn_cw,
    input  logic            btn_ccw,
    input  logic            max_enable,
    input  logic [PW_W-1:0] pw_max,
    input  logic [PW_W-1:0] us_cnt,
    input  logic            frame_update,
    output logic            servo,
    output logic [PW_W-1:0] pw,
    output logic [1:0]      direction,
    output logic            general_enable,
    output logic            at_limit
);

    localparam int unsigned EXT_W = PW_W + 1;
    localparam logic [EXT_W-1:0] MIN_X   = EXT_W'(PW_MIN);
    localparam logic [EXT_W-1:0] MAX_X   = EXT_W'(PW_MAX);
    localparam logic [EXT_W-1:0] STEP_X  = EXT_W'(STEP_US);
    localparam logic [PW_W-1:0]  INIT_PW = PW_W'(PW_INIT);
    localparam logic [PW_W-1:0]  EN_PW   = PW_W'(EN_THRESH);

    dir_e             dir_q;
    logic [EXT_W-1:0] pw_x;
    logic [EXT_W-1:0] lim_x;
    logic [EXT_W-1:0] eff_max_x;
    logic [EXT_W-1:0] stepped_x;
    logic [EXT_W-1:0] pw_next_x;

    assign direction = dir_q;

    // Effective ceiling, then step and saturate at one extra bit of headroom.
    always_comb begin
        pw_x      = {1'b0, pw};
        lim_x     = {1'b0, pw_max};
        eff_max_x = MAX_X;
        if (max_enable) begin
            eff_max_x = (lim_x < MAX_X) ? lim_x : MAX_X;
            if (eff_max_x < MIN_X) begin
                eff_max_x = MIN_X;
            end
        end

        stepped_x = pw_x;
        case (dir_q)
            DIR_CW:  stepped_x = pw_x + STEP_X;
            // Going below zero would wrap, so floor at zero and let the min clamp act.
            DIR_CCW: stepped_x = (pw_x < STEP_X) ? '0 : (pw_x - STEP_X);
            default: stepped_x = pw_x;
        endcase

        pw_next_x = stepped_x;
        if (stepped_x < MIN_X) begin
            pw_next_x = MIN_X;
        end else if (stepped_x > eff_max_x) begin
            pw_next_x = eff_max_x;
        end
    end

    // Width only moves on the frame update, so the compare never sees a mid-frame change.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            dir_q          <= DIR_STOP;
            pw             <= INIT_PW;
            servo          <= 1'b0;
            general_enable <= 1'b0;
            at_limit       <= 1'b0;
        end else begin
            dir_q          <= decode_dir(btn_cw, btn_ccw);
            if (frame_update) begin
                pw <= PW_W'(pw_next_x);
            end
            servo          <= (us_cnt < pw);
            general_enable <= (pw >= EN_PW);
            at_limit       <= (pw_x == MIN_X) || (pw_x == eff_max_x);
        end
    end

endmodule

// File: rtl/multi_servo_driver.sv
// N-channel servo PWM driver with a shared microsecond prescaler and frame counter.
// Ports:
//   CLK, RST        clock and asynchronous active-high reset
//   BTN_0/BTN_1     per-channel CW/CCW requests
//   max_enable      per-channel enable for the runtime maximum
//   pulseWidth_max  per-channel runtime maximum, channel i at [i*PW_W +: PW_W]
//   SERVO           per-channel PWM outputs
//   servo_position  per-channel pulse width in us
//   direction       per-channel registered direction, 2 bits each
//   general_enable  per-channel width >= EN_THRESH
//   at_limit        per-channel width at the effective min or max
//   frame_tick      one-cycle pulse at each frame wrap
module multi_servo_driver
    import multi_servo_driver_pkg::*;
#(
    parameter int unsigned N_CH      = 2,
    parameter int unsigned TICK_DIV  = 100,
    parameter int unsigned PERIOD_US = 20000,
    parameter int unsigned PW_W      = 16,
    parameter int unsigned PW_MIN    = 500,
    parameter int unsigned PW_MAX    = 2500,
    parameter int unsigned PW_INIT   = 1500,
    parameter int unsigned STEP_US   = 10,
    parameter int unsigned EN_THRESH = 100
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic [N_CH-1:0]      BTN_0,
    input  logic [N_CH-1:0]      BTN_1,
    input  logic [N_CH-1:0]      max_enable,
    input  logic [N_CH*PW_W-1:0] pulseWidth_max,
    output logic [N_CH-1:0]      SERVO,
    output logic [N_CH*PW_W-1:0] servo_position,
    output logic [2*N_CH-1:0]    direction,
    output logic [N_CH-1:0]      general_enable,
    output logic [N_CH-1:0]      at_limit,
    output logic                 frame_tick
);

    localparam logic [PW_W-1:0] LAST_US = PW_W'(PERIOD_US - 1);

    logic            us_tick_c;
    logic [PW_W-1:0] us_cnt;
    logic            frame_update;

    TickCounterRst #(
        .MAX (TICK_DIV)
    ) u_prescaler (
        .CLK    (CLK),
        .rst    (RST),
        .tick_c (us_tick_c)
    );

    assign frame_update = us_tick_c && (us_cnt == LAST_US);

    // Microsecond position within the frame; frame_tick marks the wrap.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            us_cnt     <= '0;
            frame_tick <= 1'b0;
        end else begin
            frame_tick <= frame_update;
            if (us_tick_c) begin
                us_cnt <= (us_cnt == LAST_US) ? '0 : (us_cnt + PW_W'(1));
            end
        end
    end

    for (genvar i = 0; i < int'(N_CH); i++) begin : g_ch
        servo_channel #(
            .PW_W      (PW_W),
            .PW_MIN    (PW_MIN),
            .PW_MAX    (PW_MAX),
            .PW_INIT   (PW_INIT),
            .STEP_US   (STEP_US),
            .EN_THRESH (EN_THRESH)
        ) u_ch (
            .CLK            (CLK),
            .RST            (RST),
            .btn_cw         (BTN_0[i]),
            .btn_ccw        (BTN_1[i]),
            .max_enable     (max_enable[i]),
            .pw_max         (pulseWidth_max[i*PW_W +: PW_W]),
            .us_cnt         (us_cnt),
            .frame_update   (frame_update),
            .servo          (SERVO[i]),
            .pw             (servo_position[i*PW_W +: PW_W]),
            .direction      (direction[2*i +: 2]),
            .general_enable (general_enable[i]),
            .at_limit       (at_limit[i])
        );
    end

endmodule

// File: tb/tb_multi_servo_driver.sv
// Self-checking bench for multi_servo_driver: directed scenarios plus randomized
// button/limit traffic, all compared against a frame-level behavioural model.
module tb_multi_servo_driver;

    localparam int N_CH      = 2;
    localparam int TICK_DIV  = 2;
    localparam int PERIOD_US = 50;
    localparam int PW_W      = 16;
    localparam int PW_MIN    = 5;
    localparam int PW_MAX    = 25;
    localparam int PW_INIT   = 15;
    localparam int STEP_US   = 3;
    localparam int EN_THRESH = 10;
    localparam int FRAME     = TICK_DIV * PERIOD_US;

    logic                 CLK = 1'b0;
    logic                 RST = 1'b1;
    logic [N_CH-1:0]      BTN_0 = '0;
    logic [N_CH-1:0]      BTN_1 = '0;
    logic [N_CH-1:0]      max_enable = '0;
    logic [N_CH*PW_W-1:0] pulseWidth_max = '0;
    logic [N_CH-1:0]      SERVO;
    logic [N_CH*PW_W-1:0] servo_position;
    logic [2*N_CH-1:0]    direction;
    logic [N_CH-1:0]      general_enable;
    logic [N_CH-1:0]      at_limit;
    logic                 frame_tick;

    multi_servo_driver #(
        .N_CH(N_CH), .TICK_DIV(TICK_DIV), .PERIOD_US(PERIOD_US), .PW_W(PW_W),
        .PW_MIN(PW_MIN), .PW_MAX(PW_MAX), .PW_INIT(PW_INIT), .STEP_US(STEP_US),
        .EN_THRESH(EN_THRESH)
    ) dut (
        .CLK(CLK), .RST(RST), .BTN_0(BTN_0), .BTN_1(BTN_1),
        .max_enable(max_enable), .pulseWidth_max(pulseWidth_max),
        .SERVO(SERVO), .servo_position(servo_position), .direction(direction),
        .general_enable(general_enable), .at_limit(at_limit), .frame_tick(frame_tick)
    );

    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_err    = 0;

    // Model state: t = clock edges since reset release; dir is +1 / -1 / 0.
    int              t;
    int              pw_m  [N_CH];
    int              dir_m [N_CH];
    logic [N_CH-1:0] servo_m;
    logic [N_CH-1:0] ge_m;
    logic [N_CH-1:0] al_m;
    logic            ft_m;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s at t=%0d: got %0h expected %0h", tag, t, got, exp);
        end
    endtask

    function automatic int eff_max(input int i);
        int lim;
        int m;
        if (!max_enable[i]) return PW_MAX;
        lim = int'(pulseWidth_max[i*PW_W +: PW_W]);
        m = (lim < PW_MAX) ? lim : PW_MAX;
        return (m < PW_MIN) ? PW_MIN : m;
    endfunction

    task automatic model_reset();
        t = 0;
        for (int i = 0; i < N_CH; i++) begin
            pw_m[i]  = PW_INIT;
            dir_m[i] = 0;
        end
        servo_m = '0;
        ge_m    = '0;
        al_m    = '0;
        ft_m    = 1'b0;
    endtask

    // One clock edge: outputs reflect the state of the cycle that just ended.
    task automatic model_edge();
        int ph;
        int em;
        int v;
        ph = t % FRAME;
        for (int i = 0; i < N_CH; i++) begin
            em = eff_max(i);
            servo_m[i] = ((ph / TICK_DIV) < pw_m[i]);
            ge_m[i]    = (pw_m[i] >= EN_THRESH);
            al_m[i]    = (pw_m[i] == PW_MIN) || (pw_m[i] == em);
            if (ph == FRAME - 1) begin
                v = pw_m[i] + STEP_US * dir_m[i];
                if (v < PW_MIN) v = PW_MIN;
                else if (v > em) v = em;
                pw_m[i] = v;
            end
            if (BTN_0[i] && !BTN_1[i])      dir_m[i] = 1;
            else if (!BTN_0[i] && BTN_1[i]) dir_m[i] = -1;
            else                            dir_m[i] = 0;
        end
        ft_m = (ph == FRAME - 1);
        t++;
    endtask

    task automatic check_outputs();
        logic [N_CH*PW_W-1:0] exp_pos;
        logic [2*N_CH-1:0]    exp_dir;
        for (int i = 0; i < N_CH; i++) begin
            exp_pos[i*PW_W +: PW_W] = PW_W'(pw_m[i]);
            exp_dir[2*i +: 2] = (dir_m[i] == 1) ? 2'b01 : (dir_m[i] == -1) ? 2'b10 : 2'b00;
        end
        check_eq("servo_position", 64'(servo_position), 64'(exp_pos));
        check_eq("direction", 64'(direction), 64'(exp_dir));
        check_eq("SERVO", 64'(SERVO), 64'(servo_m));
        check_eq("general_enable", 64'(general_enable), 64'(ge_m));
        check_eq("at_limit", 64'(at_limit), 64'(al_m));
        check_eq("frame_tick", 64'(frame_tick), 64'(ft_m));
    endtask

    task automatic cycle(input int n);
        repeat (n) begin
            @(posedge CLK);
            model_edge();
            @(negedge CLK);
            check_outputs();
        end
    endtask

    function automatic int pos_of(input int i);
        return int'(servo_position[i*PW_W +: PW_W]);
    endfunction

    task automatic set_max(input int i, input int v);
        pulseWidth_max[i*PW_W +: PW_W] = PW_W'(v);
    endtask

    int hi_cnt [N_CH];
    int ft_cnt;
    int ft_first;
    int seg;

    initial begin
        model_reset();
        // Reset state while RST is held.
        @(negedge CLK);
        @(negedge CLK);
        check_eq("rst_pos", 64'(servo_position), 64'({16'd15, 16'd15}));
        check_eq("rst_flags", 64'({SERVO, direction, general_enable, at_limit, frame_tick}), 64'(0));
        RST = 1'b0;

        // Idle frame: 30 high cycles per channel and exactly one frame_tick.
        for (int i = 0; i < N_CH; i++) hi_cnt[i] = 0;
        ft_cnt = 0;
        ft_first = -1;
        for (int c = 1; c <= FRAME; c++) begin
            cycle(1);
            for (int i = 0; i < N_CH; i++) hi_cnt[i] += int'(SERVO[i]);
            if (frame_tick) begin
                ft_cnt++;
                if (ft_first < 0) ft_first = c;
            end
        end
        check_eq("servo_hi_ch0", 64'(hi_cnt[0]), 64'(30));
        check_eq("servo_hi_ch1", 64'(hi_cnt[1]), 64'(30));
        check_eq("frame_tick_cnt", 64'(ft_cnt), 64'(1));
        check_eq("frame_tick_first", 64'(ft_first), 64'(FRAME));

        // Ch0 clockwise for four frames saturates at the global max.
        BTN_0[0] = 1'b1;
        cycle(4 * FRAME);
        BTN_0[0] = 1'b0;
        check_eq("cw_sat_ch0", 64'(pos_of(0)), 64'(25));
        check_eq("cw_idle_ch1", 64'(pos_of(1)), 64'(15));

        // Ch1 counter-clockwise for four frames saturates at the minimum.
        BTN_1[1] = 1'b1;
        cycle(4 * FRAME);
        BTN_1[1] = 1'b0;
        cycle(1);
        check_eq("ccw_sat_ch1", 64'(pos_of(1)), 64'(5));
        check_eq("ccw_ge_ch1", 64'(general_enable[1]), 64'(0));
        check_eq("ccw_al_ch1", 64'(at_limit[1]), 64'(1));
        cycle(FRAME - 1);

        // Both buttons on ch0 mean stop.
        BTN_0[0] = 1'b1;
        BTN_1[0] = 1'b1;
        cycle(2 * FRAME);
        check_eq("both_dir_ch0", 64'(direction[1:0]), 64'(0));
        check_eq("both_pos_ch0", 64'(pos_of(0)), 64'(25));
        BTN_0[0] = 1'b0;
        BTN_1[0] = 1'b0;

        // Short mid-frame pulse, gone before the update cycle.
        cycle(40);
        BTN_1[0] = 1'b1;
        cycle(10);
        BTN_1[0] = 1'b0;
        cycle(FRAME - 50);
        check_eq("glitch_pos_ch0", 64'(pos_of(0)), 64'(25));

        // Runtime max pulls the width down even in STOP.
        max_enable[0] = 1'b1;
        set_max(0, 24);
        cycle(FRAME);
        check_eq("max24_ch0", 64'(pos_of(0)), 64'(24));
        max_enable[0] = 1'b0;
        cycle(FRAME);
        check_eq("max_off_ch0", 64'(pos_of(0)), 64'(24));
        max_enable[0] = 1'b1;
        set_max(0, 20);
        cycle(FRAME);
        check_eq("max20_ch0", 64'(pos_of(0)), 64'(20));
        set_max(0, 2);
        cycle(FRAME);
        check_eq("max2_floor_ch0", 64'(pos_of(0)), 64'(5));
        max_enable[0] = 1'b0;
        cycle(FRAME);

        // Randomized buttons, limits and mid-frame glitches.
        for (int f = 0; f < 40; f++) begin
            BTN_0 = N_CH'($urandom);
            BTN_1 = N_CH'($urandom);
            max_enable = N_CH'($urandom);
            for (int i = 0; i < N_CH; i++) set_max(i, $urandom_range(0, 30));
            seg = $urandom_range(1, FRAME - 12);
            cycle(seg);
            if ($urandom_range(0, 1) == 1) begin
                BTN_0 = ~BTN_0;
                cycle($urandom_range(1, 10));
                BTN_0 = ~BTN_0;
            end
            cycle($urandom_range(1, FRAME));
        end

        // Reset asserted while both outputs are high.
        BTN_0 = '0;
        BTN_1 = '0;
        max_enable = '0;
        while (t % FRAME != 4) cycle(1);
        check_eq("pre_rst_servo", 64'(SERVO), 64'(2'b11));
        #1 RST = 1'b1;
        #1;
        check_eq("rst_servo_low", 64'(SERVO), 64'(0));
        check_eq("rst_pos_mid", 64'(servo_position), 64'({16'd15, 16'd15}));
        check_eq("rst_flags_mid", 64'({direction, general_enable, at_limit, frame_tick}), 64'(0));
        @(negedge CLK);
        @(negedge CLK);
        RST = 1'b0;
        model_reset();
        ft_first = -1;
        for (int c = 1; c <= FRAME + 5; c++) begin
            cycle(1);
            if (frame_tick && ft_first < 0) ft_first = c;
        end
        check_eq("rst_frame_restart", 64'(ft_first), 64'(FRAME));

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
